// File: rtl/wrr_stream_arbiter.sv
// N:1 weighted round-robin packet arbiter with a registered valid/ready output stage.
// Define WRR_STREAM_ARB_WEIGHT_EN to enable per-port weights; otherwise every turn is one packet.
module wrr_stream_arbiter #(
  parameter int PORT = 4,
  parameter int DATA = 32,
  parameter int WGT  = 4,
  localparam int IDX = $clog2(PORT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PORT-1:0]      in_valid_i,
  input  logic [PORT-1:0]      in_last_i,
  input  logic [PORT*DATA-1:0] in_data_i,
  output logic [PORT-1:0]      in_ready_o,
  input  logic [PORT*WGT-1:0]  weight_i,
  output logic                 out_valid_o,
  output logic                 out_last_o,
  output logic [DATA-1:0]      out_data_o,
  output logic [IDX-1:0]       out_port_o,
  input  logic                 out_ready_i
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state_q;
  logic [IDX-1:0]  ptr_q;
  logic [IDX-1:0]  gnt_q;
  logic            pkt_open_q;
  logic            out_valid_q;
  logic            out_last_q;
  logic [DATA-1:0] out_data_q;
  logic [IDX-1:0]  out_port_q;

  logic [DATA-1:0] lane_data [PORT];
  logic            accept_ok;
  logic            xfer;
  logic            beat_last;
  logic            last_turn_pkt;
  logic [IDX-1:0]  ptr_d;
  logic [IDX-1:0]  pick_d;
  logic            found;
  logic [IDX:0]    cand;

  assign accept_ok = (state_q == BURST) && (!out_valid_q || out_ready_i);
  assign xfer      = accept_ok && in_valid_i[gnt_q];
  assign beat_last = in_last_i[gnt_q];
  assign ptr_d     = (gnt_q == IDX'(PORT - 1)) ? '0 : gnt_q + IDX'(1);

  genvar gi;
  generate
    for (gi = 0; gi < PORT; gi++) begin : g_lane
      assign lane_data[gi]  = in_data_i[gi*DATA +: DATA];
      assign in_ready_o[gi] = accept_ok && (gnt_q == IDX'(gi));
    end
  endgenerate

  // First requester at or after ptr_q, wrapping modulo PORT (PORT need not be 2^n).
  always_comb begin
    pick_d = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < PORT; k++) begin
      cand = {1'b0, ptr_q} + (IDX+1)'(k);
      if (cand >= (IDX+1)'(PORT)) cand = cand - (IDX+1)'(PORT);
      if (!found && in_valid_i[cand[IDX-1:0]]) begin
        found  = 1'b1;
        pick_d = cand[IDX-1:0];
      end
    end
  end

`ifdef WRR_STREAM_ARB_WEIGHT_EN
  logic [WGT-1:0] credit_q;
  logic [WGT-1:0] lane_wgt [PORT];
  generate
    for (gi = 0; gi < PORT; gi++) begin : g_wgt
      assign lane_wgt[gi] = weight_i[gi*WGT +: WGT];
    end
  endgenerate
  assign last_turn_pkt = (credit_q == '0);
`else
  logic unused_weight;
  assign unused_weight = ^weight_i;
  assign last_turn_pkt = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      pkt_open_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_port_q  <= '0;
`ifdef WRR_STREAM_ARB_WEIGHT_EN
      credit_q    <= '0;
`endif
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_last_q  <= beat_last;
        out_data_q  <= lane_data[gnt_q];
        out_port_q  <= gnt_q;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (found) begin
            gnt_q   <= pick_d;
            state_q <= BURST;
`ifdef WRR_STREAM_ARB_WEIGHT_EN
            credit_q <= lane_wgt[pick_d];
`endif
          end
        end
        BURST: begin
          if (xfer) begin
            if (beat_last) begin
              pkt_open_q <= 1'b0;
              if (last_turn_pkt) begin
                ptr_q   <= ptr_d;
                state_q <= IDLE;
              end
`ifdef WRR_STREAM_ARB_WEIGHT_EN
              else begin
                credit_q <= credit_q - WGT'(1);
              end
`endif
            end else begin
              pkt_open_q <= 1'b1;
            end
          end else if (!pkt_open_q && !in_valid_i[gnt_q]) begin
            // Idle between packets forfeits the rest of the turn; mid-packet gaps keep the lock.
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_data_o  = out_data_q;
  assign out_port_o  = out_port_q;

endmodule

// File: doc/wrr_stream_arbiter.md
Name: wrr_stream_arbiter

Overview:
- N:1 weighted round-robin packet arbiter. It shares one valid/ready stream output between PORT requesters.
- A grant is locked for a whole packet (until in_last) and is held for up to weight+1 consecutive packets per turn.
- The output is registered, giving one-cycle latency. It sits in front of any shared sink (bus master, FIFO, link) fed by several packet sources.

Parameters:
- PORT, 4, number of requesters (any value >=2, not required to be 2^n).
- DATA, 32, payload width per port.
- WGT, 4, width of each per-port weight field.
- IDX, $clog2(PORT), derived width of the port index (not to be overridden).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  PORT  per-port valid
- in_last  input  PORT  per-port end-of-packet flag, qualified by in_valid
- in_data  input  PORT*DATA  per-port payload; port i occupies bits [i*DATA +: DATA]
- in_ready  output  PORT  per-port ready; at most one bit is set at any time
- weight  input  PORT*WGT  quasi-static per-port weight; port i occupies [i*WGT +: WGT]
- out_valid  output  1  output valid (registered)
- out_last  output  1  output end-of-packet (registered)
- out_data  output  DATA  output payload (registered)
- out_port  output  IDX  source port of the current output beat (registered)
- out_ready  input  1  downstream ready

Behaviour:
- Reset values:
  - outputs: out_valid=0, out_last=0, out_data=0, out_port=0, in_ready=0.
  - internal: state=IDLE, ptr=0, gnt=0, credit=0, pkt_open=0.
- State IDLE:
  - in_ready=0.
  - If any in_valid is set, select the first set bit scanning ptr, ptr+1, ... PORT-1, 0, ... modulo PORT.
  - Latch that port into gnt, load credit=weight[gnt], go to BURST.
  - This arbitration costs one cycle. No beat is transferred in IDLE.
- State BURST:
  - in_ready[gnt] = !out_valid || out_ready. All other in_ready bits are 0.
  - Input transfer: in_valid[gnt] && in_ready[gnt]. Next cycle out_valid=1, out_data, out_last and out_port=gnt carry the beat.
  - Output register: out_valid clears when out_ready=1 and no new transfer occurs. Output fields hold while out_valid && !out_ready.
  - Transfer with in_last=0: pkt_open<=1.
  - Transfer with in_last=1 and credit==0:
    - pkt_open<=0, ptr<=(gnt+1) mod PORT, go to IDLE.
  - Transfer with in_last=1 and credit!=0:
    - pkt_open<=0, credit<=credit-1, stay in BURST.
  - No transfer, pkt_open=0 and in_valid[gnt]=0:
    - Release the turn: ptr<=(gnt+1) mod PORT, go to IDLE. Unused credit is discarded.
  - No transfer and pkt_open=1: hold the grant indefinitely. A mid-packet valid gap never releases the lock.
- Throughput: one beat per cycle inside a burst. One idle cycle on the input side between turns.
- Fairness: each port gets at most weight+1 packets per turn. Any continuously requesting port is served within PORT-1 turns.
- ptr wrap: the increment from PORT-1 goes to 0. Indices >=PORT are never produced.
- weight is sampled only on the IDLE->BURST transition. Changes during a burst take effect on the next turn.
- Non-granted ports' in_last/in_data are ignored.
- Reset mid-packet: all state returns to reset values next cycle. A partially forwarded packet is truncated; upstream/downstream recovery is the system's responsibility.

Optional Feature:
- Macro WRR_STREAM_ARB_WEIGHT_EN.
- Defined: weighted behaviour as above.
- Undefined: the weight port is present but ignored and credit is treated as constant 0. Every turn is exactly one packet (plain packet round-robin), and the credit counter logic is not synthesized.

Test Plan:
- PORT=4, weights 0, all 4 ports send continuous 2-beat packets, out_ready=1 -> out_port packet order 0,1,2,3,0,...; every packet's 2 beats are contiguous.
- Weight WRR_STREAM_ARB_WEIGHT_EN defined, weight[0]=2, others 0, all requesting 1-beat packets -> out_port sequence 0,0,0,1,2,3,0,0,0,...
- Port 1 packet of 4 beats with in_valid dropped for 3 cycles after beat 2, port 2 requesting -> no port-2 beat appears until port 1's last beat is output.
- out_ready held 0 for 5 cycles mid-burst -> out_valid/out_data stable, in_ready[gnt]=0 while out_valid=1, no beat lost or duplicated.
- PORT=3, only port 2 requesting, then ports 0 and 2 -> ptr wraps 2->0, port 0 granted next; out_port never equals 3.
- Reset asserted during a burst -> next cycle out_valid=0, in_ready=0, out_port=0; first grant after reset goes to the lowest requesting port index.
